// File: rtl/seq_pkg.sv
// Shared types and constants for the sequencer tempo path.
// Widths here fix the BPM, step-index and accumulator-increment sizes.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } seq_state_e;

    localparam int STEPS_PER_PATTERN   = 16;
    localparam int HALF_TICKS_PER_BEAT = 8;
    localparam int BPM_W               = 8;
    localparam int IDX_W               = 4;
    localparam int INC_W               = BPM_W + 3;

    // A quarter note spans four 16th steps of two half-ticks each.
    function automatic logic [INC_W-1:0] bpm_to_inc(input logic [BPM_W-1:0] bpm);
        return INC_W'(bpm) * INC_W'(HALF_TICKS_PER_BEAT);
    endfunction

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator: adds inc each enabled cycle and fires tick on wrap past THRESH.
// The remainder is kept on wrap, so the long-run rate is exact without a divider.
module phase_accum
    import seq_pkg::*;
#(
    parameter logic [32:0] THRESH = 33'd3_000_000_000
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic             tick
);

    logic [32:0] acc_reg;
    logic [32:0] sum;

    // acc stays below THRESH < 2^32, so the sum cannot overflow 33 bits.
    always_comb begin
        sum = acc_reg + 33'(inc);
    end

    assign tick = en && (sum >= THRESH);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= tick ? (sum - THRESH) : sum;
        end
    end

endmodule

// File: rtl/step_clock.sv
// Tempo generator: turns a BPM setting into a 16th-note Step square wave,
// a 0..15 step position and a strobe on every quarter-note step.
module step_clock
    import seq_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Play,
    input  logic [BPM_W-1:0] Bpm,
    output logic             Step,
    output logic [IDX_W-1:0] StepIndex,
    output logic             Beat,
    output logic             Running
);

    localparam longint      THRESH_L = longint'(CLK_HZ) * 60;
    localparam logic [32:0] THRESH   = THRESH_L[32:0];

    generate
        if (THRESH_L >= 64'sd4294967296 || CLK_HZ < 1) begin : g_clk_hz_check
            $error("step_clock: CLK_HZ*60 must be positive and below 2^32");
        end
    endgenerate

    seq_state_e       state_reg, state_next;
    logic             step_reg, step_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             beat_reg, beat_next;
    logic             running_reg, running_next;
    logic [BPM_W-1:0] bpm_l_reg, bpm_l_next;

    logic             accum_en;
    logic             accum_clr;
    logic             half_tick;

    // Accumulate only while running with Play still high; a falling Play
    // suppresses any half-tick due in the same cycle.
    assign accum_en  = (state_reg == RUN) && Play;
    assign accum_clr = !accum_en;

    phase_accum #(
        .THRESH (THRESH)
    ) u_phase_accum (
        .Clock  (Clock),
        .nReset (nReset),
        .clr    (accum_clr),
        .en     (accum_en),
        .inc    (bpm_to_inc(bpm_l_reg)),
        .tick   (half_tick)
    );

    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        idx_next     = idx_reg;
        beat_next    = 1'b0;
        running_next = running_reg;
        bpm_l_next   = bpm_l_reg;

        case (state_reg)
            IDLE: begin
                step_next    = 1'b0;
                running_next = 1'b0;
                if (Play) begin
                    state_next = START;
                end
            end

            START: begin
                step_next    = 1'b1;
                idx_next     = '0;
                beat_next    = 1'b1;
                running_next = 1'b1;
                bpm_l_next   = Bpm;
                state_next   = RUN;
            end

            RUN: begin
                if (!Play) begin
                    state_next   = IDLE;
                    step_next    = 1'b0;
                    running_next = 1'b0;
                end else if (half_tick) begin
                    step_next = !step_reg;
                    if (!step_reg) begin
                        // Index width wraps naturally at STEPS_PER_PATTERN.
                        idx_next  = idx_reg + 1'b1;
                        beat_next = (idx_next[1:0] == 2'b00);
                    end else begin
                        // Tempo is only picked up at mid-step, never shortening a high phase.
                        bpm_l_next = Bpm;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg   <= IDLE;
            step_reg    <= 1'b0;
            idx_reg     <= '0;
            beat_reg    <= 1'b0;
            running_reg <= 1'b0;
            bpm_l_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            idx_reg     <= idx_next;
            beat_reg    <= beat_next;
            running_reg <= running_next;
            bpm_l_reg   <= bpm_l_next;
        end
    end

    assign Step      = step_reg;
    assign StepIndex = idx_reg;
    assign Beat      = beat_reg;
    assign Running   = running_reg;

endmodule

// File: tb/tb_step_clock.sv
// Self-checking bench for step_clock at CLK_HZ=1000 (THRESH=60000), with a
// reference model that derives step position from the total phase advanced.
module tb_step_clock;

    localparam int     CLK_HZ = 1000;
    localparam longint THRESH = 60000;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       play = 1'b0;
    logic [7:0] bpm = 8'd0;
    logic       step;
    logic [3:0] step_index;
    logic       beat;
    logic       running;

    step_clock #(.CLK_HZ(CLK_HZ)) dut (
        .Clock     (clk),
        .nReset    (n_reset),
        .Play      (play),
        .Bpm       (bpm),
        .Step      (step),
        .StepIndex (step_index),
        .Beat      (beat),
        .Running   (running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: half-ticks fired = floor(total phase / THRESH).
    typedef enum {M_IDLE, M_START, M_RUN} mode_e;
    mode_e      m_mode = M_IDLE;
    longint     m_phase = 0;
    longint     m_halves = 0;
    int         m_bpml = 0;
    logic       e_step = 1'b0;
    logic [3:0] e_idx = 4'd0;
    logic       e_beat = 1'b0;
    logic       e_running = 1'b0;

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_halves = 0; m_bpml = 0;
        e_step = 1'b0; e_idx = 4'd0; e_beat = 1'b0; e_running = 1'b0;
    endtask

    task automatic model_edge();
        e_beat = 1'b0;
        case (m_mode)
            M_IDLE: begin
                e_step = 1'b0; e_running = 1'b0;
                if (play) m_mode = M_START;
            end
            M_START: begin
                e_step = 1'b1; e_idx = 4'd0; e_beat = 1'b1; e_running = 1'b1;
                m_phase = 0; m_halves = 0; m_bpml = int'(bpm); m_mode = M_RUN;
            end
            default: begin
                if (!play) begin
                    m_mode = M_IDLE; e_step = 1'b0; e_running = 1'b0;
                end else begin
                    m_phase += longint'(m_bpml) * 8;
                    if (m_phase / THRESH > m_halves) begin
                        m_halves = m_phase / THRESH;
                        if (m_halves % 2 == 0) begin
                            e_step = 1'b1;
                            e_idx  = 4'((m_halves / 2) % 16);
                            e_beat = (e_idx % 4 == 0);
                        end else begin
                            e_step = 1'b0;
                            m_bpml = int'(bpm);
                        end
                    end
                end
            end
        endcase
    endtask

    function automatic bit m_tick_due();
        return (m_mode == M_RUN) && play &&
               ((m_phase + longint'(m_bpml) * 8) / THRESH > m_halves);
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic clk_edge();
        @(posedge clk);
        if (n_reset) model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; play = 1'b0; bpm = 8'd0;
        model_reset();
        repeat (3) clk_edge();
        total++;
        if ({step, step_index, beat, running} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state got s/i/b/r=%b/%0d/%b/%b want all 0", step, step_index, beat, running);
        end
        n_reset = 1'b1;
        repeat (2) clk_edge();
        total++;
        if ({step, running} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle got step=%b running=%b want 0/0", step, running);
        end
        $display("[tb] test_reset done");
    endtask

    task automatic test_basic();
        int last_t = -1;
        logic prev = 1'b0;
        int beats = 0;
        bpm = 8'd125; play = 1'b1;
        for (int i = 0; i < 1930; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL basic cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (beat === 1'b1) beats++;
            if (step !== prev) begin
                if (last_t >= 0) begin
                    total++;
                    if (cyc - last_t != 60) begin
                        bad++;
                        $display("FAIL basic_half_period got %0d want 60", cyc - last_t);
                    end
                end
                last_t = cyc; prev = step;
            end
        end
        total++;
        if (beats != 5) begin
            bad++;
            $display("FAIL basic_beat_count got %0d want 5", beats);
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_basic done");
    endtask

    task automatic test_nonint();
        int t0 = -1, last_t = -1, n = 0;
        logic prev = 1'b0;
        bpm = 8'd120; play = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL nonint cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (step !== prev) begin
                if (t0 < 0) t0 = cyc;
                else begin
                    n++;
                    total++;
                    if (cyc - last_t != 62 && cyc - last_t != 63) begin
                        bad++;
                        $display("FAIL nonint_interval got %0d want 62 or 63", cyc - last_t);
                    end
                    if (n == 16) begin
                        total++;
                        if (cyc - t0 != 1000) begin
                            bad++;
                            $display("FAIL nonint_16_halves got %0d want 1000", cyc - t0);
                        end
                    end
                end
                last_t = cyc; prev = step;
            end
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_nonint done");
    endtask

    task automatic test_tempo_change();
        int t0 = -1, last_t = -1, n = 0;
        logic prev = 1'b0;
        bpm = 8'd125; play = 1'b1;
        for (int i = 0; i < 300; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL tempo cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (step !== prev) begin
                if (t0 < 0) t0 = cyc;
                else begin
                    n++;
                    total++;
                    if (cyc - last_t != ((n == 1) ? 60 : 30)) begin
                        bad++;
                        $display("FAIL tempo_interval n=%0d got %0d want %0d", n, cyc - last_t, (n == 1) ? 60 : 30);
                    end
                end
                last_t = cyc; prev = step;
            end
            if (t0 >= 0 && cyc - t0 == 20) bpm = 8'd250;
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_tempo_change done");
    endtask

    task automatic test_stop_restart();
        bit found = 1'b0;
        bpm = 8'd125; play = 1'b1;
        for (int i = 0; i < 3000 && !found; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL stop_run cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (e_idx == 4'd7 && m_tick_due()) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stop_timeout got no due half-tick at index 7 want one within 3000 cycles");
        end
        play = 1'b0;
        clk_edge();
        total++;
        if ({step, running, beat, step_index} !== {1'b0, 1'b0, 1'b0, 4'd7}) begin
            bad++;
            $display("FAIL stop_latency got s/r/b/i=%b/%b/%b/%0d want 0/0/0/7", step, running, beat, step_index);
        end
        repeat (3) clk_edge();
        play = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL restart cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
        end
        total++;
        if ({step, step_index, beat, running} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL restart_start got s/i/b/r=%b/%0d/%b/%b want 1/0/1/1", step, step_index, beat, running);
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_stop_restart done");
    endtask

    task automatic test_bpm_zero_reset();
        bpm = 8'd125; play = 1'b1;
        for (int i = 0; i < 500; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL bpm0 cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (i == 70) bpm = 8'd0;
        end
        total++;
        if ({step, running} !== 2'b01) begin
            bad++;
            $display("FAIL bpm0_hold got step=%b running=%b want 0/1", step, running);
        end
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({step, step_index, beat, running} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset got s/i/b/r=%b/%0d/%b/%b want all 0", step, step_index, beat, running);
        end
        bpm = 8'd125;
        clk_edge();
        n_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
        end
        total++;
        if ({step, beat, running} !== 3'b111) begin
            bad++;
            $display("FAIL release_start got s/b/r=%b/%b/%b want 1/1/1", step, beat, running);
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_bpm_zero_reset done");
    endtask

    task automatic test_random();
        bpm = 8'($urandom_range(60, 255)); play = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL random cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if ($urandom_range(0, 249) == 0) play = !play;
            if ($urandom_range(0, 79) == 0)
                bpm = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(60, 255));
        end
        play = 1'b0;
        repeat (3) clk_edge();
        $display("[tb] test_random done");
    endtask

    // A small stand-in for loop_counter with Loops=2: it watches Step through
    // a 2-flop synchroniser and drops Play after the 32nd step ends.
    task automatic test_integration();
        int seen = 0, rises = 0;
        logic s0 = 1'b0, s1 = 1'b0, s1_prev = 1'b0, prev = 1'b0;
        bit dropped = 1'b0;
        bpm = 8'd250; play = 1'b1;
        for (int i = 0; i < 3000 && !dropped; i++) begin
            clk_edge();
            total++;
            if ({step, step_index, beat, running} !== {e_step, e_idx, e_beat, e_running}) begin
                bad++;
                $display("FAIL integ cyc=%0d got s/i/b/r=%b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc, step, step_index, beat, running, e_step, e_idx, e_beat, e_running);
            end
            if (step === 1'b1 && prev === 1'b0) rises++;
            prev = step;
            s1_prev = s1; s1 = s0; s0 = step;
            if (s1 && !s1_prev) seen++;
            if (!s1 && s1_prev && seen == 32) begin
                play = 1'b0;
                dropped = 1'b1;
            end
        end
        total++;
        if (!dropped) begin
            bad++;
            $display("FAIL integ_timeout got %0d synchronised rises want 32 within 3000 cycles", seen);
        end
        for (int i = 0; i < 100; i++) begin
            clk_edge();
            if (step === 1'b1 && prev === 1'b0) rises++;
            prev = step;
        end
        total++;
        if (rises != 32 || {step, running} !== 2'b00) begin
            bad++;
            $display("FAIL integ_rises got rises=%0d step=%b running=%b want 32/0/0", rises, step, running);
        end
        $display("[tb] test_integration done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got simulation still running want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_nonint();
        test_tempo_change();
        test_stop_restart();
        test_bpm_zero_reset();
        test_random();
        test_integration();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_clock.md
# step_clock

Tempo generator directly upstream of `loop_counter`. It converts an 8-bit BPM setting into a 16th-note step square wave on `Step`, gated by the `Play` level that `loop_counter` returns. It also produces the 4-bit position within the 16-step pattern and a one-cycle beat strobe for the pattern RAM and audio generators. A phase accumulator gives exact long-run tempo for any BPM without a divider.

## Interface
- `CLK_HZ`, default 50_000_000: Clock frequency in Hz. The constraint `CLK_HZ*60 < 2^32` is checked at elaboration.
- `Clock`  in  1: system clock; all logic on the rising edge.
- `nReset`  in  1: asynchronous, active-low reset.
- `Play`  in  1: run enable from `loop_counter`, same clock domain, level-sensitive.
- `Bpm`  in  8: tempo in quarter notes per minute. A value of 0 means frozen.
- `Step`  out  1: step square wave; each rising edge marks the start of a step. Reset value 0.
- `StepIndex`  out  4: current step 0–15 within the pattern. Reset value 0.
- `Beat`  out  1: one-cycle strobe when a step starts with `StepIndex % 4 == 0`. Reset value 0.
- `Running`  out  1: high while stepping is active. Reset value 0.

## Operation
- **Half-tick rate.** Each 16th note is two half-ticks, so half-ticks occur at `Bpm*8` per minute.
- **Accumulator registers.** `acc` is 33 bits unsigned. The constant `THRESH = CLK_HZ*60`. The increment `inc = BpmL*8` is 11 bits, where `BpmL` is `Bpm` latched.
- **Accumulator update.** Each cycle while RUN:
  - if `acc + inc >= THRESH`: `acc <= acc + inc - THRESH` and a half-tick fires;
  - otherwise `acc <= acc + inc`.
  - `acc` never reaches or exceeds `THRESH`.
- **Half-tick action.** On a half-tick, `Step` toggles.
  - On a 0→1 toggle, `StepIndex` increments mod 16, wrapping 15→0.
  - `Beat` pulses for one cycle if the new index is 0, 4, 8 or 12.
- **Bpm latching.** `BpmL` loads `Bpm` at RUN entry and on every `Step` 1→0 toggle, i.e. at the mid-step point. A tempo change therefore never shortens the current high phase.
- **State machine, IDLE and START.**
  - IDLE: `Running=0`, `Step=0`, `acc=0`. The FSM moves to START when `Play` is seen high.
  - START: lasts one cycle. `Step<=1`, `StepIndex<=0`, `Beat<=1`, `Running<=1`, `acc<=0`, `BpmL<=Bpm`. The FSM then moves to RUN.
- **State machine, RUN.** Accumulate as above.
  - If `Play` falls, go to IDLE next cycle: `Step<=0`, `Running<=0`, `acc<=0`. `StepIndex` holds its last value.
  - If `Play` is low while a half-tick is due in the same cycle, `Play` wins: no toggle and no `Beat`.
- **Bpm = 0.** `inc = 0`, so there are no half-ticks and `Step` holds its level; `Running` stays 1. Because `BpmL` only reloads at mid-step, a 0 latched during the low phase is permanent until `Play` cycles through 0. That behaviour is accepted.
- **Restart.** A `Play` 0→1 transition always restarts at step 0 and does not resume the previous position.
- **Reset.** `nReset` low at any time forces IDLE and all outputs and registers to 0 immediately. When reset releases with `Play` high, the FSM enters START on the first clock.

## Timing
- **Start latency.** If `Play` is sampled high at edge n, then at edge n+1: `Step=1`, `StepIndex=0`, `Beat=1`, `Running=1`. `loop_counter`'s 2-flop synchroniser sees this rise 2 cycles later.
- **Half-tick period.** Average `THRESH/(BpmL*8)` cycles. Individual periods are the floor or ceiling of that value, and the jitter is at most 1 cycle.
- **Stop latency.** When `Play` falls at edge n, `Step` and `Running` are 0 at edge n+1.
- **Outputs.** All outputs are registered, with no combinational path from inputs.

## Structure
- **Package `seq_pkg`:** the FSM state enum (IDLE, START, RUN), `STEPS_PER_PATTERN = 16`, `HALF_TICKS_PER_BEAT = 8`, and the width constants `BPM_W = 8` and `IDX_W = 4`.
- **Sub-module `phase_accum`:**
  - parameter `THRESH`;
  - inputs `Clock`, `nReset`, `clr`, `en`, `inc[10:0]`;
  - output `tick`, a one-cycle pulse.
- **Top level:** `step_clock` holds the FSM, the `Step` toggle, `StepIndex`, `Beat` and the `BpmL` register.

## Test plan
All scenarios use `CLK_HZ=1000`, so `THRESH=60000`.
- **Basic stepping.** Reset, then `Bpm=125`, `Play=1` → START at the first edge. Half-ticks every exactly 60 cycles. `Step` is high 60 cycles and low 60 cycles. `StepIndex` runs 0..15 then wraps to 0 at step 17. `Beat` pulses at indices 0, 4, 8 and 12.
- **Non-integer period.** `Bpm=120` → `inc=960`. Half-tick intervals alternate between 62 and 63 cycles. Total is exactly 1000 cycles over 16 half-ticks.
- **Tempo change mid-step.** Change `Bpm` 125→250 during a `Step`-high phase → the current high lasts 60 cycles. The new 30-cycle half-periods begin after the next 1→0 toggle.
- **Stop and restart.** Drop `Play` at `StepIndex=7` in the same cycle a half-tick is due → the next cycle has `Step=0` and `Running=0`, with no extra `Beat`. Raise `Play` again → `StepIndex=0` and `Beat=1` one cycle later.
- **Bpm = 0 and reset mid-run.** Set `Bpm=0` during the low phase → `Step` holds 0 indefinitely. Then assert `nReset` mid-run → all outputs are 0 asynchronously. Release with `Play=1` → START on the first edge.
- **Integration.** Connect to `loop_counter` with `Loops=2` → exactly 32 `Step` rises occur before `Play` drops and `step_clock` returns to IDLE.
